// File: rtl/raster_gen.sv
// Raster address generator: walks a cfg_w x cfg_h window starting at cfg_addr,
// emitting one pixel address per accepted beat with row/window end markers.
module raster_gen #(
  parameter int W_DATA = 16,
  parameter int W_DIM  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_DATA-1:0] cfg_addr,
  input  logic [W_DIM-1:0]  cfg_w,
  input  logic [W_DIM-1:0]  cfg_h,
  input  logic [W_DATA-1:0] cfg_stride,
  output logic              busy,
  output logic              done,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [W_DATA-1:0] dout_data,
  output logic [1:0]        dout_eot
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [W_DIM-1:0]  DIM_ZERO = {W_DIM{1'b0}};
  localparam logic [W_DIM-1:0]  DIM_ONE  = W_DIM'(1);
  localparam logic [W_DATA-1:0] DATA_ONE = W_DATA'(1);

  state_t            state_r, state_s;
  logic [W_DATA-1:0] addr_r, addr_s;
  logic [W_DATA-1:0] row_start_r, row_start_s;
  logic [W_DATA-1:0] stride_r, stride_s;
  logic [W_DIM-1:0]  w_r, w_s;
  logic [W_DIM-1:0]  h_r, h_s;
  logic [W_DIM-1:0]  col_r, col_s;
  logic [W_DIM-1:0]  row_r, row_s;
  logic [1:0]        eot_r, eot_s;
  logic              done_r, done_s;
  logic              last_col_s, last_row_s;

  assign last_col_s = (col_r == (w_r - DIM_ONE));
  assign last_row_s = (row_r == (h_r - DIM_ONE));

  // Next-state: latch window on start, advance column/row on each accepted beat.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    row_start_s = row_start_r;
    stride_s    = stride_r;
    w_s         = w_r;
    h_s         = h_r;
    col_s       = col_r;
    row_s       = row_r;
    done_s      = 1'b0;
    eot_s       = 2'b00;

    case (state_r)
      IDLE: begin
        if (start) begin
          if ((cfg_w != DIM_ZERO) && (cfg_h != DIM_ZERO)) begin
            state_s     = RUN;
            addr_s      = cfg_addr;
            row_start_s = cfg_addr;
            stride_s    = cfg_stride;
            w_s         = cfg_w;
            h_s         = cfg_h;
            col_s       = DIM_ZERO;
            row_s       = DIM_ZERO;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (dout_ready) begin
          if (last_col_s) begin
            if (last_row_s) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              addr_s      = row_start_r + stride_r;
              row_start_s = row_start_r + stride_r;
              col_s       = DIM_ZERO;
              row_s       = row_r + DIM_ONE;
            end
          end else begin
            addr_s = addr_r + DATA_ONE;
            col_s  = col_r + DIM_ONE;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // End markers are registered alongside the address they describe.
    if (state_s == RUN) begin
      eot_s[0] = (col_s == (w_s - DIM_ONE));
      eot_s[1] = (col_s == (w_s - DIM_ONE)) && (row_s == (h_s - DIM_ONE));
    end else begin
      eot_s = 2'b00;
    end
  end

  // State and datapath registers; reset aborts any scan immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      addr_r      <= {W_DATA{1'b0}};
      row_start_r <= {W_DATA{1'b0}};
      stride_r    <= {W_DATA{1'b0}};
      w_r         <= DIM_ZERO;
      h_r         <= DIM_ZERO;
      col_r       <= DIM_ZERO;
      row_r       <= DIM_ZERO;
      eot_r       <= 2'b00;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      row_start_r <= row_start_s;
      stride_r    <= stride_s;
      w_r         <= w_s;
      h_r         <= h_s;
      col_r       <= col_s;
      row_r       <= row_s;
      eot_r       <= eot_s;
      done_r      <= done_s;
    end
  end

  assign busy       = (state_r == RUN);
  assign dout_valid = (state_r == RUN);
  assign dout_data  = addr_r;
  assign dout_eot   = eot_r;
  assign done       = done_r;

endmodule

// File: tb/tb_raster_gen.sv
// Self-checking bench for raster_gen: a window-walk model checked every cycle,
// plus literal beat lists for the directed scenarios.
module tb_raster_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_addr = 16'h0000;
  logic [7:0]  cfg_w = 8'd0;
  logic [7:0]  cfg_h = 8'd0;
  logic [15:0] cfg_stride = 16'h0000;
  logic        busy, done, dout_valid;
  logic        dout_ready = 1'b1;
  logic [15:0] dout_data;
  logic [1:0]  dout_eot;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [17:0] exp_q[$];
  logic [17:0] beat_log[$];
  bit          model_run = 1'b0;
  bit          done_next = 1'b0;
  bit          stalled = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  logic [1:0]  prev_eot = 2'b00;
  int          done_cnt = 0;

  raster_gen #(.W_DATA(16), .W_DIM(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_addr(cfg_addr), .cfg_w(cfg_w),
    .cfg_h(cfg_h), .cfg_stride(cfg_stride), .busy(busy), .done(done),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_eot(dout_eot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected beats of a window: row r, column c at base + r*stride + c.
  task automatic fill_window(input logic [15:0] base, input logic [7:0] w,
                             input logic [7:0] h, input logic [15:0] stride);
    logic [15:0] a;
    logic [1:0]  e;
    for (int r = 0; r < int'(h); r++) begin
      for (int c = 0; c < int'(w); c++) begin
        a    = 16'(32'(base) + 32'(r) * 32'(stride) + 32'(c));
        e[0] = (c == int'(w) - 1);
        e[1] = (c == int'(w) - 1) && (r == int'(h) - 1);
        exp_q.push_back({e, a});
      end
    end
  endtask

  // Per-cycle compare and model update, sampled on the falling edge.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(dout_data), 32'd0);
        chk("rst_eot", 32'(dout_eot), 32'd0);
        model_run = 1'b0;
        done_next = 1'b0;
        stalled   = 1'b0;
        exp_q.delete();
      end else begin
        chk("busy", 32'(busy), 32'(model_run));
        chk("valid", 32'(dout_valid), 32'(model_run));
        chk("done", 32'(done), 32'(done_next));
        if (done) done_cnt++;
        done_next = 1'b0;
        if (model_run) begin
          if (stalled) begin
            chk("stall_data", 32'(dout_data), 32'(prev_data));
            chk("stall_eot", 32'(dout_eot), 32'(prev_eot));
          end
          if (dout_ready) begin
            stalled = 1'b0;
            if (exp_q.size() == 0) begin
              chk("extra_beat", 32'(dout_data), 32'hFFFF_FFFF);
              model_run = 1'b0;
            end else begin
              e = exp_q.pop_front();
              chk("beat_data", 32'(dout_data), 32'(e[15:0]));
              chk("beat_eot", 32'(dout_eot), 32'(e[17:16]));
              beat_log.push_back({dout_eot, dout_data});
              if (exp_q.size() == 0) begin
                model_run = 1'b0;
                done_next = 1'b1;
              end
            end
          end else begin
            stalled   = 1'b1;
            prev_data = dout_data;
            prev_eot  = dout_eot;
          end
        end else begin
          stalled = 1'b0;
          if (start) begin
            if (cfg_w == 8'd0 || cfg_h == 8'd0) begin
              done_next = 1'b1;
            end else begin
              fill_window(cfg_addr, cfg_w, cfg_h, cfg_stride);
              model_run = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] a, input logic [7:0] w,
                          input logic [7:0] h, input logic [15:0] s);
    beat_log.delete();
    @(posedge clk); #1;
    cfg_addr = a; cfg_w = w; cfg_h = h; cfg_stride = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble config so a design that re-reads it during the scan is caught
    cfg_addr = 16'hDEAD; cfg_w = 8'd7; cfg_h = 8'd9; cfg_stride = 16'h0333;
  endtask

  task automatic run_until_idle(input bit stall_pattern);
    logic [15:0] pat;
    int i;
    pat = 16'b1011_0010_0110_1001;
    i = 0;
    while (model_run && i < 200) begin
      @(posedge clk); #1;
      if (stall_pattern) dout_ready = pat[i % 16];
      i++;
    end
    chk("scan_timeout", 32'(model_run), 32'd0);
    dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string nm, input logic [17:0] exp_l[$]);
    chk({nm, "_len"}, 32'(beat_log.size()), 32'(exp_l.size()));
    for (int i = 0; i < exp_l.size() && i < beat_log.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), 32'(beat_log[i]), 32'(exp_l[i]));
  endtask

  initial begin
    logic [17:0] exp_3x2[$];
    logic [17:0] exp_1x1[$];
    logic [17:0] exp_wrap[$];
    int          d0;
    exp_3x2  = '{{2'b00, 16'h0100}, {2'b00, 16'h0101}, {2'b01, 16'h0102},
                 {2'b00, 16'h0110}, {2'b00, 16'h0111}, {2'b11, 16'h0112}};
    exp_1x1  = '{{2'b11, 16'h0042}};
    exp_wrap = '{{2'b00, 16'hFFFE}, {2'b00, 16'hFFFF}, {2'b00, 16'h0000},
                 {2'b11, 16'h0001}};

    #2;
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_valid", 32'(dout_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // 3x2 window, ready held high
    do_start(16'h0100, 8'd3, 8'd2, 16'h0010);
    run_until_idle(1'b0);
    check_log("w3h2", exp_3x2);
    chk("w3h2_busy", 32'(busy), 32'd0);

    // same window with stalls
    do_start(16'h0100, 8'd3, 8'd2, 16'h0010);
    run_until_idle(1'b1);
    check_log("w3h2_stall", exp_3x2);

    // single pixel
    d0 = done_cnt;
    do_start(16'h0042, 8'd1, 8'd1, 16'h0010);
    run_until_idle(1'b0);
    check_log("w1h1", exp_1x1);
    chk("w1h1_done", 32'(done_cnt - d0), 32'd1);

    // empty window: done only
    d0 = done_cnt;
    do_start(16'h0200, 8'd0, 8'd5, 16'h0010);
    run_until_idle(1'b0);
    chk("w0_beats", 32'(beat_log.size()), 32'd0);
    chk("w0_done", 32'(done_cnt - d0), 32'd1);

    // asynchronous reset after second beat
    do_start(16'h0100, 8'd3, 8'd2, 16'h0010);
    for (int i = 0; i < 50 && beat_log.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    chk("pre_rst_beats", 32'(beat_log.size()), 32'd2);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_valid", 32'(dout_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_data", 32'(dout_data), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    do_start(16'h0100, 8'd3, 8'd2, 16'h0010);
    run_until_idle(1'b0);
    check_log("post_rst", exp_3x2);

    // address wrap, with start pulses during the scan and on the final beat
    do_start(16'hFFFE, 8'd4, 8'd1, 16'h0010);
    cfg_w = 8'd2; cfg_h = 8'd2; cfg_addr = 16'h0500;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    run_until_idle(1'b0);
    check_log("wrap", exp_wrap);
    chk("wrap_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/raster_gen.md
RASTER_GEN -- requirements
Module: raster_gen

Interface
REQ-001 SHALL have parameter W_DATA, default 16: address width of output beats.
REQ-002 SHALL have parameter W_DIM, default 8: width of window width/height fields.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a window scan.
REQ-006 SHALL have port cfg_addr  input  W_DATA: address of first pixel of window.
REQ-007 SHALL have port cfg_w  input  W_DIM: window width in pixels.
REQ-008 SHALL have port cfg_h  input  W_DIM: window height in rows.
REQ-009 SHALL have port cfg_stride  input  W_DATA: address distance between row starts.
REQ-010 SHALL have port busy  output  1: scan in progress.
REQ-011 SHALL have port done  output  1: one-cycle pulse, scan complete.
REQ-012 SHALL have port dout_valid  output  1: beat available.
REQ-013 SHALL have port dout_ready  input  1: downstream accepts beat.
REQ-014 SHALL have port dout_data  output  W_DATA: pixel address.
REQ-015 SHALL have port dout_eot  output  2: bit0 last beat of row, bit1 last beat of window.

Function
REQ-016 SHALL implement FSM with states IDLE and RUN; busy=1 exactly in RUN.
REQ-017 SHALL, in IDLE, on start=1 with cfg_w!=0 and cfg_h!=0, latch all cfg_* inputs and enter RUN on the next edge.
REQ-018 SHALL, in IDLE, on start=1 with cfg_w==0 or cfg_h==0, stay in IDLE, emit no beat, assert done for one cycle on the next edge.
REQ-019 SHALL ignore start while in RUN, including in the cycle of the final transfer.
REQ-020 SHALL assert dout_valid in the first RUN cycle (start-to-first-valid latency 1 cycle); dout_valid=1 throughout RUN.
REQ-021 SHALL count a transfer only when dout_valid=1 and dout_ready=1; sustain 1 transfer per cycle with dout_ready held high.
REQ-022 SHALL hold dout_data and dout_eot stable while dout_valid=1 and dout_ready=0.
REQ-023 SHALL output first beat = cfg_addr; within a row each transfer increments address by 1.
REQ-024 SHALL, on transfer of the last column, next output row_start+cfg_stride, where row_start is the first address of the current row.
REQ-025 SHALL perform all address arithmetic modulo 2^W_DATA (silent wrap).
REQ-026 SHALL drive dout_eot[0]=1 on column cfg_w-1 of every row; dout_eot[1]=1 only on column cfg_w-1 of row cfg_h-1 (final beat eot=2'b11); otherwise 0.
REQ-027 SHALL, on the final transfer, return to IDLE on that edge (dout_valid=0, busy=0 next cycle) and assert done for exactly that next cycle.
REQ-028 SHALL support cfg_w=1 (every beat eot[0]=1) and cfg_h=1 (eot[1] on the row's last beat).
REQ-029 SHALL ignore changes on cfg_* inputs while in RUN.

Reset
REQ-030 SHALL, while rst=0, force state IDLE, busy=0, done=0, dout_valid=0, dout_data=0, dout_eot=0, counters 0, regardless of clock.
REQ-031 SHALL abort a scan in progress on reset with no further beats; the first start after rst returns high is honoured normally.

Verification
REQ-032 SHALL test: cfg_addr=0x100, w=3, h=2, stride=0x10, ready=1 -> 0x100,0x101,0x102(eot 01),0x110,0x111,0x112(eot 11); done 1 cycle after last; busy low.
REQ-033 SHALL test: same config, dout_ready toggled pseudo-randomly -> identical sequence, data/eot stable across every stall, no beats dropped or duplicated.
REQ-034 SHALL test: w=1, h=1, cfg_addr=0x42 -> single beat 0x42 eot=11, then done.
REQ-035 SHALL test: w=0, h=5 -> dout_valid never asserted, done pulses one cycle after start, busy stays 0.
REQ-036 SHALL test: rst low asynchronously after 2nd beat of 3x2 scan -> dout_valid and busy 0 immediately; new start after release yields full correct sequence.
REQ-037 SHALL test: cfg_addr=0xFFFE, w=4, h=1 -> 0xFFFE, 0xFFFF, 0x0000, 0x0001(eot 11); start pulsed during RUN has no effect.
